// File: rtl/som_image_fetch.sv
// Streams one stored 64x64 RGB image out of the shared image RAM to the SOM engine.
// A small credit-limited FIFO hides the 1-cycle RAM read latency and downstream stalls.
module som_image_fetch #(
  parameter int DEPTH   = 4,
  parameter int NUM_IMG = 15
) (
  input  logic        CK,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  img_idx,
  input  logic        abort,
  output logic [17:0] A,
  output logic        OE,
  output logic        WE,
  input  logic [23:0] Q,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_data,
  output logic [11:0] pix_idx,
  output logic        pix_last,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [CW:0] DEPTH_C   = (CW+1)'(DEPTH);
  localparam logic [4:0]  NUM_IMG_C = 5'(NUM_IMG);
  localparam logic [11:0] LAST_PIX  = 12'hFFF;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FIN} state_t;

  state_t         state_q, state_d;
  logic [3:0]     img_q, img_d;
  logic [11:0]    rd_ptr_q, rd_ptr_d;
  logic [17:0]    a_q, a_d;
  logic           pending_q, pending_d;
  logic [11:0]    pend_idx_q, pend_idx_d;
  logic           err_q, err_d;
  logic [AW-1:0]  wp_q, wp_d, hp_q, hp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [23:0]    fifo_data_q [DEPTH];
  logic [11:0]    fifo_idx_q  [DEPTH];

  logic           flush, push, pop, bad_idx;
  logic [CW:0]    inflight;
  logic [23:0]    head_data;
  logic [11:0]    head_idx;

  assign flush     = abort && (state_q != S_IDLE);
  assign push      = pending_q && !flush;
  assign pix_valid = (cnt_q != '0);
  assign pop       = pix_valid && pix_ready;
  assign bad_idx   = ({1'b0, img_idx} >= NUM_IMG_C);
  // Outstanding work = buffered pixels plus the read still in flight.
  assign inflight  = {1'b0, cnt_q} + {{CW{1'b0}}, pending_q};
  assign head_data = fifo_data_q[hp_q];
  assign head_idx  = fifo_idx_q[hp_q];

  always_comb begin
    state_d    = state_q;
    img_d      = img_q;
    rd_ptr_d   = rd_ptr_q;
    a_d        = a_q;
    pending_d  = 1'b0;
    pend_idx_d = pend_idx_q;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (bad_idx) begin
            err_d = 1'b1;
          end else begin
            img_d      = img_idx;
            a_d        = {2'b00, img_idx, 12'd0};
            pending_d  = 1'b1;
            pend_idx_d = 12'd0;
            rd_ptr_d   = 12'd1;
            state_d    = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (inflight < DEPTH_C) begin
          a_d        = {2'b00, img_q, rd_ptr_q};
          pending_d  = 1'b1;
          pend_idx_d = rd_ptr_q;
          rd_ptr_d   = rd_ptr_q + 12'd1;
          if (rd_ptr_q == LAST_PIX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the final pixel is handed over on this edge.
        if (!pending_q && ((cnt_q == '0) || ((cnt_q == CW'(1)) && pop))) state_d = S_FIN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d   = S_IDLE;
      pending_d = 1'b0;
      a_d       = a_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    wp_d  = wp_q;
    hp_d  = hp_q;
    if (flush) begin
      cnt_d = '0;
      wp_d  = '0;
      hp_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  hp_d = hp_q + AW'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      img_q      <= '0;
      rd_ptr_q   <= '0;
      a_q        <= '0;
      pending_q  <= 1'b0;
      pend_idx_q <= '0;
      err_q      <= 1'b0;
      wp_q       <= '0;
      hp_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      img_q      <= img_d;
      rd_ptr_q   <= rd_ptr_d;
      a_q        <= a_d;
      pending_q  <= pending_d;
      pend_idx_q <= pend_idx_d;
      err_q      <= err_d;
      wp_q       <= wp_d;
      hp_q       <= hp_d;
      cnt_q      <= cnt_d;
    end
  end

  // Return stage: RAM data for the in-flight read lands in the FIFO.
  always_ff @(posedge CK) begin
    if (push) begin
      fifo_data_q[wp_q] <= Q;
      fifo_idx_q[wp_q]  <= pend_idx_q;
    end
  end

  assign A        = a_q;
  assign OE       = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign WE       = 1'b0;
  assign pix_data = pix_valid ? head_data : '0;
  assign pix_idx  = pix_valid ? head_idx : '0;
  assign pix_last = pix_valid && (head_idx == LAST_PIX);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign err      = err_q;

endmodule
